// File: rtl/mux_scan_rr.sv
// Registered N-channel selector with manual and round-robin scan modes and a dwell counter.
// Optional out_parity port is enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                      out_parity
`endif
);

    localparam logic [1:0]      ST_WAIT      = 2'd0;
    localparam logic [1:0]      ST_LOAD      = 2'd1;
    localparam logic [1:0]      ST_HOLD      = 2'd2;
    localparam logic [SELW:0]   CH_NUM       = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] PTR_RST      = SELW'(CHANNELS - 1);
    localparam logic [7:0]      DWELL_RELOAD = 8'(DWELL - 1);

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    logic [1:0]       state_r, state_s;
    logic [7:0]       cnt_r, cnt_s;
    logic [SELW-1:0]  ptr_r, ptr_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic [SELW-1:0]  ch_r, ch_s;
    logic             valid_r, valid_s;
    logic             parity_r, parity_s;

    logic [WIDTH-1:0] ch_word_s [CHANNELS];
    logic [SELW:0]    idx_s;
    logic             scan_found_s;
    logic [SELW-1:0]  scan_cand_s;
    logic             man_ok_s;
    logic             cand_valid_s;
    logic [SELW-1:0]  cand_s;
    logic             load_s;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign ch_word_s[k] = din[k*WIDTH +: WIDTH];
    end

    // Round-robin search: ptr+1, ptr+2, ... wrapping, with ptr itself examined last.
    always_comb begin
        scan_found_s = 1'b0;
        scan_cand_s  = {SELW{1'b0}};
        idx_s        = {(SELW+1){1'b0}};
        for (int i = 1; i <= CHANNELS; i++) begin
            idx_s = {1'b0, ptr_r} + i[SELW:0];
            if (idx_s >= CH_NUM) begin
                idx_s = idx_s - CH_NUM;
            end else begin
                idx_s = idx_s;
            end
            if (!scan_found_s && ch_en[idx_s[SELW-1:0]]) begin
                scan_found_s = 1'b1;
                scan_cand_s  = idx_s[SELW-1:0];
            end else begin
                scan_found_s = scan_found_s;
            end
        end
    end

    // Candidate selection for the current mode.
    always_comb begin
        if ({1'b0, sel} < CH_NUM) begin
            man_ok_s = ch_en[sel];
        end else begin
            man_ok_s = 1'b0;
        end
        if (mode) begin
            cand_valid_s = scan_found_s;
            cand_s       = scan_cand_s;
        end else begin
            cand_valid_s = man_ok_s;
            cand_s       = sel;
        end
    end

    // Next-state logic for the WAIT/LOAD/HOLD sequencer and the output sample.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        ptr_s    = ptr_r;
        data_s   = data_r;
        ch_s     = ch_r;
        valid_s  = valid_r;
        parity_s = parity_r;
        load_s   = 1'b0;
        case (state_r)
            ST_WAIT: begin
                valid_s = 1'b0;
                if (cnt_r == 8'd0) begin
                    if (cand_valid_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_LOAD: begin
                valid_s = 1'b0;
                if (cand_valid_s) begin
                    load_s = 1'b1;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (DWELL == 1) begin
                        if (cand_valid_s) begin
                            load_s = 1'b1;
                        end else begin
                            valid_s = 1'b0;
                            state_s = ST_LOAD;
                        end
                    end else begin
                        valid_s = 1'b0;
                        cnt_s   = DWELL_RELOAD;
                        state_s = ST_WAIT;
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_WAIT;
                cnt_s   = 8'd0;
                valid_s = 1'b0;
            end
        endcase
        if (load_s) begin
            data_s   = ch_word_s[cand_s];
            ch_s     = cand_s;
            valid_s  = 1'b1;
            parity_s = even_parity(ch_word_s[cand_s]);
            state_s  = ST_HOLD;
            if (mode) begin
                ptr_s = cand_s;
            end else begin
                ptr_s = ptr_r;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // State and output registers; reset discards any held sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_WAIT;
            cnt_r    <= 8'd0;
            ptr_r    <= PTR_RST;
            data_r   <= {WIDTH{1'b0}};
            ch_r     <= {SELW{1'b0}};
            valid_r  <= 1'b0;
            parity_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            ptr_r    <= ptr_s;
            data_r   <= data_s;
            ch_r     <= ch_s;
            valid_r  <= valid_s;
            parity_r <= parity_s;
        end
    end

    assign out_data  = data_r;
    assign out_ch    = ch_r;
    assign out_valid = valid_r;
`ifdef MUX_SCAN_PARITY_EN
    assign out_parity = parity_r;
`else
    logic unused_parity_s;
    assign unused_parity_s = parity_r;
`endif

endmodule
